encoder_32_5: RTL and testbench

ENCODER_32_5 -- requirements
Module: encoder_32_5

---
 rtl/encoder_32_5.sv | 103 ++++++++++
 tb/tb_encoder_32_5.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/encoder_32_5.sv
// rtl/encoder_32_5.sv - sticky 32-to-5 request encoder with valid/ready handshake
module encoder_32_5 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        flush,
    output logic        enc_valid,
    input  logic        enc_ready,
    output logic [4:0]  enc,
    output logic [31:0] pending
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  ptr;
    logic [4:0]  ptr_nxt;
    logic [4:0]  enc_nxt;
    logic        valid_nxt;
    logic [31:0] pending_nxt;
    logic [4:0]  base;
    logic [4:0]  idx;
    logic [4:0]  sel;
    logic        found;

    // Pick the first pending line at or above the search base, wrapping 31 -> 0.
    always_comb begin
        base  = (ROUND_ROBIN != 0) ? ptr : 5'd0;
        idx   = base;
        sel   = base;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idx = base + 5'(i);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; flush overrides everything except reset.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending | req;
        enc_nxt     = enc;
        valid_nxt   = enc_valid;
        ptr_nxt     = ptr;
        if (flush) begin
            pending_nxt = 32'd0;
            valid_nxt   = 1'b0;
            state_nxt   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        enc_nxt   = sel;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (enc_valid && enc_ready) begin
                        // A request arriving on the accept cycle re-arms its own bit.
                        pending_nxt = (pending & ~(32'd1 << enc)) | req;
                        valid_nxt   = 1'b0;
                        ptr_nxt     = enc + 5'd1;
                        state_nxt   = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 32'd0;
            enc       <= 5'd0;
            enc_valid <= 1'b0;
            ptr       <= 5'd0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            enc       <= enc_nxt;
            enc_valid <= valid_nxt;
            ptr       <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_encoder_32_5.sv
// tb/tb_encoder_32_5.sv - directed bench for encoder_32_5, rotating and fixed priority
module tb_encoder_32_5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enc_ready;
    logic [31:0] req;
    logic        rr_valid;
    logic [4:0]  rr_enc;
    logic [31:0] rr_pend;
    logic        fx_valid;
    logic [4:0]  fx_enc;
    logic [31:0] fx_pend;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] req;
        logic [4:0]  exp_rr;
        logic [4:0]  exp_fx;
    } vec_t;

    vec_t vecs [11];

    // Free-running clock.
    always #5 clk = ~clk;

    encoder_32_5 #(.ROUND_ROBIN(1)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flush     (flush),
        .enc_valid (rr_valid),
        .enc_ready (enc_ready),
        .enc       (rr_enc),
        .pending   (rr_pend)
    );

    encoder_32_5 #(.ROUND_ROBIN(0)) u_fx (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flush     (flush),
        .enc_valid (fx_valid),
        .enc_ready (enc_ready),
        .enc       (fx_enc),
        .pending   (fx_pend)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus.
    initial begin
        int k;
        vecs[0]  = '{32'h0000_0020, 5'd5,  5'd5};
        vecs[1]  = '{32'h0000_0003, 5'd0,  5'd0};
        vecs[2]  = '{32'h8000_0001, 5'd31, 5'd0};
        vecs[3]  = '{32'h0001_0100, 5'd8,  5'd8};
        vecs[4]  = '{32'h0001_0100, 5'd16, 5'd8};
        vecs[5]  = '{32'h8000_0000, 5'd31, 5'd31};
        vecs[6]  = '{32'h0000_0001, 5'd0,  5'd0};
        vecs[7]  = '{32'hFFFF_FFFF, 5'd1,  5'd0};
        vecs[8]  = '{32'h0000_0006, 5'd2,  5'd1};
        vecs[9]  = '{32'h4000_0000, 5'd30, 5'd30};
        vecs[10] = '{32'h8000_0004, 5'd31, 5'd2};

        rst = 1'b1; req = 32'd0; flush = 1'b0; enc_ready = 1'b0;
        step();
        step();
        chk("reset_pending", rr_pend, 32'd0);
        chk("reset_valid", {31'd0, rr_valid}, 32'd0);
        chk("reset_enc", {27'd0, rr_enc}, 32'd0);
        chk("reset_fx_valid", {31'd0, fx_valid}, 32'd0);
        rst = 1'b0;

        // Held two-line request with ready held: rotating alternates, fixed repeats 0.
        req = 32'h8000_0001; enc_ready = 1'b1; k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            step();
            if (rr_valid) begin
                chk("rr_alternate", {27'd0, rr_enc}, (k % 2 == 1) ? 32'd31 : 32'd0);
                chk("fx_repeat_valid", {31'd0, fx_valid}, 32'd1);
                chk("fx_repeat_enc", {27'd0, fx_enc}, 32'd0);
                k++;
            end
        end
        chk("rr_alternate_count", k, 32'd4);
        step();
        req = 32'd0; enc_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;

        // Table: one-cycle request pulse, check latency, code, accept, then flush leftovers.
        for (int v = 0; v < 11; v++) begin
            req = vecs[v].req;
            step();
            req = 32'd0;
            chk($sformatf("v%0d_valid_n1", v), {31'd0, rr_valid}, 32'd0);
            step();
            chk($sformatf("v%0d_rr_valid", v), {31'd0, rr_valid}, 32'd1);
            chk($sformatf("v%0d_rr_enc", v), {27'd0, rr_enc}, {27'd0, vecs[v].exp_rr});
            chk($sformatf("v%0d_fx_valid", v), {31'd0, fx_valid}, 32'd1);
            chk($sformatf("v%0d_fx_enc", v), {27'd0, fx_enc}, {27'd0, vecs[v].exp_fx});
            enc_ready = 1'b1;
            step();
            enc_ready = 1'b0;
            chk($sformatf("v%0d_valid_drop", v), {31'd0, rr_valid}, 32'd0);
            if (v == 0) chk("single_pending_clear", rr_pend, 32'd0);
            flush = 1'b1;
            step();
            flush = 1'b0;
            chk($sformatf("v%0d_flush_pending", v), rr_pend | fx_pend, 32'd0);
        end

        // Backpressure: code 7 held while bit 0 arrives.
        req = 32'h0000_0080;
        step();
        req = 32'd0;
        step();
        chk("bp_enc7", {27'd0, rr_enc}, 32'd7);
        req = 32'h0000_0001;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_valid", {31'd0, rr_valid}, 32'd1);
            chk("bp_hold_enc", {27'd0, rr_enc}, 32'd7);
        end
        chk("bp_pending_rr", rr_pend, 32'h0000_0081);
        chk("bp_pending_fx", fx_pend, 32'h0000_0081);
        req = 32'd0; enc_ready = 1'b1;
        step();
        enc_ready = 1'b0;
        chk("bp_idle_gap", {31'd0, rr_valid}, 32'd0);
        step();
        chk("bp_next_valid", {31'd0, rr_valid}, 32'd1);
        chk("bp_next_enc", {27'd0, rr_enc}, 32'd0);
        enc_ready = 1'b1;
        step();
        enc_ready = 1'b0;

        // Same-cycle re-request of the accepted code.
        req = 32'h0000_0008;
        step();
        step();
        chk("rereq_first", {27'd0, fx_enc}, 32'd3);
        enc_ready = 1'b1;
        step();
        enc_ready = 1'b0; req = 32'd0;
        chk("rereq_pending_fx", fx_pend, 32'h0000_0008);
        chk("rereq_pending_rr", rr_pend, 32'h0000_0008);
        step();
        chk("rereq_again_valid", {31'd0, fx_valid}, 32'd1);
        chk("rereq_again_enc", {27'd0, fx_enc}, 32'd3);
        enc_ready = 1'b1;
        step();
        enc_ready = 1'b0;
        chk("rereq_cleared", fx_pend | rr_pend, 32'd0);

        // Flush while holding a code; same-cycle request discarded.
        req = 32'h0000_0010;
        step();
        req = 32'd0;
        step();
        chk("flush_pre_enc", {27'd0, rr_enc}, 32'd4);
        flush = 1'b1; req = 32'h0000_0200;
        step();
        flush = 1'b0; req = 32'd0;
        chk("flush_valid", {31'd0, rr_valid}, 32'd0);
        chk("flush_pending", rr_pend | fx_pend, 32'd0);
        chk("flush_enc_hold", {27'd0, rr_enc}, 32'd4);
        enc_ready = 1'b1;
        step();
        enc_ready = 1'b0;
        chk("ready_no_valid", {31'd0, rr_valid | fx_valid}, 32'd0);

        // Reset while holding a code; everything else asserted is ignored.
        req = 32'h0004_0000;
        step();
        req = 32'd0;
        step();
        chk("rst_pre_enc", {27'd0, rr_enc}, 32'd18);
        rst = 1'b1; req = 32'h0000_00FF; flush = 1'b1; enc_ready = 1'b1;
        step();
        chk("rst_valid", {31'd0, rr_valid}, 32'd0);
        chk("rst_pending", rr_pend, 32'd0);
        chk("rst_enc", {27'd0, rr_enc}, 32'd0);
        rst = 1'b0; flush = 1'b0; enc_ready = 1'b0;
        req = 32'h8000_0001;
        step();
        req = 32'd0;
        step();
        chk("post_rst_valid", {31'd0, rr_valid}, 32'd1);
        chk("post_rst_ptr0", {27'd0, rr_enc}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
